// File: rtl/flag_branch_stage_if.sv
// rtl/flag_branch_stage_if.sv - EX-side instruction bundle feeding the flag/branch stage
interface flag_branch_stage_if #(
  parameter int DW = 16
);
  logic          in_valid;
  logic [DW-1:0] in_result;
  logic          in_v;
  logic          in_n;
  logic          set_znv;
  logic          set_z;

  modport master (
    output in_valid, in_result, in_v, in_n, set_znv, set_z
  );

  modport slave (
    input  in_valid, in_result, in_v, in_n, set_znv, set_z
  );
endinterface

// File: rtl/flag_branch_stage.sv
// rtl/flag_branch_stage.sv - EX->MEM register, Z/V/N flag owner, branch resolver, overflow counter
module flag_branch_stage #(
  parameter int DW     = 16,
  parameter int OVF_CW = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  flag_branch_stage_if.slave    ex,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  br_req,
  input  logic [2:0]            br_ccc,
  input  logic                  ovf_clr,
  output logic                  out_valid,
  output logic [DW-1:0]         out_result,
  output logic                  flag_z,
  output logic                  flag_v,
  output logic                  flag_n,
  output logic                  br_done,
  output logic                  br_taken,
  output logic [OVF_CW-1:0]     ovf_cnt
);

  typedef enum logic [2:0] {
    CC_NEQ    = 3'b000,
    CC_EQ     = 3'b001,
    CC_GT     = 3'b010,
    CC_LT     = 3'b011,
    CC_GTE    = 3'b100,
    CC_LTE    = 3'b101,
    CC_OVFL   = 3'b110,
    CC_UNCOND = 3'b111
  } ccc_e;

  logic commit;
  logic br_go;
  logic res_zero;
  logic nz, nv, nn;
  logic take;
  logic ovf_inc;
  ccc_e ccc;

  assign commit   = ex.in_valid & ~stall & ~flush;
  assign br_go    = br_req & ~stall & ~flush;
  assign res_zero = (ex.in_result == '0);
  assign ovf_inc  = commit & ex.set_znv & ex.in_v;
  assign ccc      = ccc_e'(br_ccc);

  // Next-edge flag values, so a branch sharing the cycle with a flag-setter sees the update
  always_comb begin
    nz = flag_z;
    nv = flag_v;
    nn = flag_n;
    if (commit) begin
      if (ex.set_znv) begin
        nz = res_zero;
        nv = ex.in_v;
        nn = ex.in_n;
      end else if (ex.set_z) begin
        nz = res_zero;
      end
    end
  end

  always_comb begin
    take = 1'b0;
    case (ccc)
      CC_NEQ:    take = ~nz;
      CC_EQ:     take = nz;
      CC_GT:     take = ~nz & ~nn;
      CC_LT:     take = nn;
      CC_GTE:    take = nz | ~nn;
      CC_LTE:    take = nz | nn;
      CC_OVFL:   take = nv;
      CC_UNCOND: take = 1'b1;
      default:   take = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_result <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
    end else if (!stall) begin
      out_valid  <= ex.in_valid;
      if (ex.in_valid) begin
        out_result <= ex.in_result;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_z <= 1'b0;
      flag_v <= 1'b0;
      flag_n <= 1'b0;
    end else if (commit) begin
      flag_z <= nz;
      flag_v <= nv;
      flag_n <= nn;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_done  <= 1'b0;
      br_taken <= 1'b0;
    end else if (br_go) begin
      br_done  <= 1'b1;
      br_taken <= take;
    end else begin
      br_done  <= 1'b0;
    end
  end

  // Clear beats increment; counter sticks at all-ones rather than wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_cnt <= '0;
    end else if (!stall) begin
      if (ovf_clr) begin
        ovf_cnt <= '0;
      end else if (ovf_inc && (ovf_cnt != '1)) begin
        ovf_cnt <= ovf_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_flag_branch_stage.sv
// tb/tb_flag_branch_stage.sv - self-checking bench for flag_branch_stage
module tb_flag_branch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall, flush, br_req, ovf_clr;
  logic [2:0]  br_ccc;
  logic        out_valid, flag_z, flag_v, flag_n, br_done, br_taken;
  logic [15:0] out_result;
  logic [7:0]  ovf_cnt;

  flag_branch_stage_if #(.DW(16)) ex ();

  flag_branch_stage #(.DW(16), .OVF_CW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex         (ex.slave),
    .stall      (stall),
    .flush      (flush),
    .br_req     (br_req),
    .br_ccc     (br_ccc),
    .ovf_clr    (ovf_clr),
    .out_valid  (out_valid),
    .out_result (out_result),
    .flag_z     (flag_z),
    .flag_v     (flag_v),
    .flag_n     (flag_n),
    .br_done    (br_done),
    .br_taken   (br_taken),
    .ovf_cnt    (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state
  bit m_valid, m_z, m_v, m_n, m_done, m_taken;
  int m_res, m_cnt;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit cond(input int c, input bit z, input bit v, input bit n);
    case (c)
      0: return !z;
      1: return z;
      2: return !z && !n;
      3: return n;
      4: return z || !n;
      5: return z || n;
      6: return v;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    m_valid = 0; m_z = 0; m_v = 0; m_n = 0; m_done = 0; m_taken = 0;
    m_res = 0; m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_valid"}, int'(out_valid), int'(m_valid));
    if (m_valid) chk({tag, "_result"}, int'(out_result), m_res);
    chk({tag, "_z"}, int'(flag_z), int'(m_z));
    chk({tag, "_v"}, int'(flag_v), int'(m_v));
    chk({tag, "_n"}, int'(flag_n), int'(m_n));
    chk({tag, "_done"}, int'(br_done), int'(m_done));
    if (m_done) chk({tag, "_taken"}, int'(br_taken), int'(m_taken));
    chk({tag, "_cnt"}, int'(ovf_cnt), m_cnt);
  endtask

  // Apply one cycle of stimulus, advance the model by the same edge, then compare
  task automatic step(input string tag, input bit vld, input int res, input bit v, input bit n,
                      input bit znv, input bit sz, input bit st, input bit fl,
                      input bit br, input int ccc, input bit clr);
    bit cm;
    ex.in_valid = vld; ex.in_result = 16'(res); ex.in_v = v; ex.in_n = n;
    ex.set_znv = znv; ex.set_z = sz;
    stall = st; flush = fl; br_req = br; br_ccc = 3'(ccc); ovf_clr = clr;
    @(posedge clk);
    cm = vld && !st && !fl;
    if (cm) begin
      m_valid = 1;
      m_res = res & 16'hFFFF;
      if (znv) begin
        m_z = ((res & 16'hFFFF) == 0); m_v = v; m_n = n;
      end else if (sz) begin
        m_z = ((res & 16'hFFFF) == 0);
      end
    end else if (fl || !st) begin
      m_valid = 0;
    end
    if (br && !st && !fl) begin
      m_done = 1;
      m_taken = cond(ccc, m_z, m_v, m_n);
    end else begin
      m_done = 0;
    end
    if (!st) begin
      if (clr) m_cnt = 0;
      else if (cm && znv && v && m_cnt < 255) m_cnt = m_cnt + 1;
    end
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    ex.in_valid = 0; ex.in_result = '0; ex.in_v = 0; ex.in_n = 0;
    ex.set_znv = 0; ex.set_z = 0;
    stall = 0; flush = 0; br_req = 0; br_ccc = 0; ovf_clr = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all("rst");
    chk("rst_result", int'(out_result), 0);
    chk("rst_taken", int'(br_taken), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle("idle1");
    idle("idle2");

    // add producing zero with overflow
    step("add", 1, 16'h0000, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    chk("add_z", int'(flag_z), 1);
    chk("add_v", int'(flag_v), 1);
    chk("add_cnt", int'(ovf_cnt), 1);

    // logic op touches Z only
    step("logic", 1, 16'h8000, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    chk("logic_z", int'(flag_z), 0);
    chk("logic_v", int'(flag_v), 1);
    chk("logic_n", int'(flag_n), 0);

    // bypass of same-cycle flag update
    step("byp_gt", 1, 16'h0005, 0, 0, 1, 0, 0, 0, 1, 2, 0);
    chk("byp_gt_taken", int'(br_taken), 1);
    step("byp_eq", 1, 16'h0005, 0, 0, 1, 0, 0, 0, 1, 1, 0);
    chk("byp_eq_taken", int'(br_taken), 0);
    idle("byp_after");

    // flush dominates stall, then stall alone holds
    step("flush", 1, 16'h0000, 1, 1, 1, 0, 1, 1, 1, 7, 0);
    step("stall", 1, 16'h0000, 1, 1, 1, 0, 1, 0, 1, 7, 1);
    chk("stall_cnt", int'(ovf_cnt), 1);

    // saturation of the overflow counter
    for (int i = 0; i < 300; i++) begin
      step("sat", 1, i + 1, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    end
    chk("sat_cnt", int'(ovf_cnt), 255);
    step("clr_stall", 1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 1);
    chk("clr_stall_cnt", int'(ovf_cnt), 255);
    step("clr", 1, 1, 1, 0, 1, 0, 0, 0, 0, 0, 1);
    chk("clr_cnt", int'(ovf_cnt), 0);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 3));
      step("rnd", $urandom_range(0, 3) != 0,
           (r == 0) ? 0 : int'($urandom_range(0, 16'hFFFF)),
           1'($urandom), 1'($urandom), $urandom_range(0, 2) == 0, 1'($urandom),
           $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
           1'($urandom), int'($urandom_range(0, 7)), $urandom_range(0, 40) == 0);
    end

    // asynchronous reset mid-operation discards in-flight state
    ex.in_valid = 1; ex.in_result = 16'h1234; ex.set_znv = 1; ex.in_v = 1; ex.in_n = 1;
    br_req = 1; br_ccc = 3'd7; stall = 0; flush = 0; ovf_clr = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("midrst");
    chk("midrst_result", int'(out_result), 0);
    chk("midrst_taken", int'(br_taken), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle("post_rst");
    step("post_add", 1, 16'hFFFE, 0, 1, 1, 0, 0, 0, 1, 3, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
